// File: rtl/alu_rs_pkg.sv
// Shared types for the ALU reservation station and its sibling stations.
// Provides the physical register width, CDB port count, station depth,
// the RS_t dispatch payload, the cdb_bcast_t broadcast record and a
// tag-match helper used for wakeup.
package alu_rs_pkg;

  localparam int unsigned P_WIDTH      = 6;
  localparam int unsigned NUM_CDB      = 2;
  localparam int unsigned ALU_RS_DEPTH = 8;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  // Dispatched micro-op as held in a reservation station slot
  typedef struct packed {
    logic               valid;
    logic [31:0]        pc;
    logic [31:0]        imm;
    alu_op_t            alu_op;
    logic [P_WIDTH-1:0] rd_paddr;
    logic [P_WIDTH-1:0] rs1_paddr;
    logic [P_WIDTH-1:0] rs2_paddr;
    logic               rs1_use;
    logic               rs2_use;
  } RS_t;

  // One CDB broadcast port
  typedef struct packed {
    logic               valid;
    logic [P_WIDTH-1:0] paddr;
  } cdb_bcast_t;

  // True when a broadcast carries the given physical register tag
  function automatic logic bcast_hit(input cdb_bcast_t b, input logic [P_WIDTH-1:0] tag);
    return b.valid && (b.paddr == tag);
  endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// Oldest-ready picker for collapsing-queue reservation stations.
// Slot 0 is the oldest, so this is a lowest-index priority encoder.
// Ports:
//   req     - per-slot request (valid and operands ready)
//   idx_c   - index of the lowest set request bit (0 when none)
//   found_c - at least one request bit set
module rs_oldest_select #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0] req,
  output logic [IDX_W-1:0] idx_c,
  output logic             found_c
);

  // Scan from the youngest down so the oldest hit is written last
  always_comb begin
    idx_c   = '0;
    found_c = 1'b0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_c   = IDX_W'(i);
        found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Reservation station feeding the ALU. Collapsing queue: slot index is age
// order (slot 0 oldest). Tracks operand readiness from the busy table at
// dispatch and from CDB broadcasts afterwards, and presents the oldest
// ready entry as the ALU's next-cycle input.
//
// Build option: ALU_RS_WAKEUP_BYPASS_EN lets select also count same-cycle
// CDB hits as ready (0-cycle wakeup-to-issue). Undefined: select sees only
// registered ready bits (1-cycle wakeup-to-issue).
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   flush               - drop every entry at the edge (dispatch dropped too)
//   dispatch_valid      - insert dispatch_entry this cycle (ignored when full)
//   dispatch_entry      - RS_t payload to insert
//   dispatch_rs1_ready  - rs1 already ready in the busy table
//   dispatch_rs2_ready  - rs2 already ready in the busy table
//   rs_full             - no free slot (from registered state only)
//   rs_count            - occupied slots
//   cdb_valid/cdb_paddr - CDB broadcast ports used for wakeup
//   issue_entry         - selected entry with valid=1, or all-zero
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int unsigned DEPTH   = alu_rs_pkg::ALU_RS_DEPTH,
  parameter int unsigned NUM_CDB = alu_rs_pkg::NUM_CDB,
  parameter int unsigned P_WIDTH = alu_rs_pkg::P_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            dispatch_valid,
  input  RS_t                             dispatch_entry,
  input  logic                            dispatch_rs1_ready,
  input  logic                            dispatch_rs2_ready,
  output logic                            rs_full,
  output logic [$clog2(DEPTH+1)-1:0]      rs_count,
  input  logic [NUM_CDB-1:0]              cdb_valid,
  input  logic [NUM_CDB-1:0][P_WIDTH-1:0] cdb_paddr,
  output RS_t                             issue_entry
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Registered slot state
  logic [DEPTH-1:0] slot_valid;
  logic [DEPTH-1:0] r1_rdy;
  logic [DEPTH-1:0] r2_rdy;
  RS_t              slot_entry [DEPTH];
  logic [CNT_W-1:0] count;
  logic             full;

  // Next-state
  logic [DEPTH-1:0] n_valid;
  logic [DEPTH-1:0] n_r1;
  logic [DEPTH-1:0] n_r2;
  RS_t              n_entry [DEPTH];
  logic [CNT_W-1:0] count_n;

  // Slot view extended by one empty slot so the shift never indexes out of range
  logic [DEPTH:0]   ext_valid;
  logic [DEPTH:0]   ext_r1;
  logic [DEPTH:0]   ext_r2;
  logic [DEPTH:0]   ext_w1;
  logic [DEPTH:0]   ext_w2;
  RS_t              ext_entry [DEPTH+1];

  cdb_bcast_t       cdb [NUM_CDB];

  logic [DEPTH-1:0] eff_r1;
  logic [DEPTH-1:0] eff_r2;
  logic [DEPTH-1:0] req;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic [DEPTH-1:0] shift;

  logic             disp_acc;
  logic             d_r1;
  logic             d_r2;
  logic [CNT_W-1:0] ins_idx;

  // Pack the broadcast ports
  always_comb begin
    for (int k = 0; k < int'(NUM_CDB); k++) begin
      cdb[k].valid = cdb_valid[k];
      cdb[k].paddr = cdb_paddr[k];
    end
  end

  // Extended slot view and per-slot CDB tag matches
  always_comb begin
    ext_valid = {1'b0, slot_valid};
    ext_r1    = {1'b0, r1_rdy};
    ext_r2    = {1'b0, r2_rdy};
    for (int i = 0; i < int'(DEPTH); i++) begin
      ext_entry[i] = slot_entry[i];
    end
    ext_entry[DEPTH] = '0;
    ext_w1 = '0;
    ext_w2 = '0;
    for (int i = 0; i <= int'(DEPTH); i++) begin
      for (int k = 0; k < int'(NUM_CDB); k++) begin
        if (bcast_hit(cdb[k], ext_entry[i].rs1_paddr)) ext_w1[i] = 1'b1;
        if (bcast_hit(cdb[k], ext_entry[i].rs2_paddr)) ext_w2[i] = 1'b1;
      end
    end
  end

  // Readiness seen by select
  always_comb begin
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    eff_r1 = r1_rdy | ext_w1[DEPTH-1:0];
    eff_r2 = r2_rdy | ext_w2[DEPTH-1:0];
`else
    eff_r1 = r1_rdy;
    eff_r2 = r2_rdy;
`endif
    req = slot_valid & eff_r1 & eff_r2;
  end

  rs_oldest_select #(
    .DEPTH (DEPTH)
  ) u_select (
    .req     (req),
    .idx_c   (sel_idx),
    .found_c (sel_found)
  );

  // Issue is unconditional: the ALU has no stall path
  always_comb begin
    issue_entry = '0;
    if (sel_found) begin
      issue_entry       = slot_entry[sel_idx];
      issue_entry.valid = 1'b1;
    end
  end

  // Dispatch acceptance, initial readiness (incl. same-cycle CDB bypass), count
  always_comb begin
    disp_acc = dispatch_valid && !full && !flush;
    d_r1 = !dispatch_entry.rs1_use || (dispatch_entry.rs1_paddr == '0) || dispatch_rs1_ready;
    d_r2 = !dispatch_entry.rs2_use || (dispatch_entry.rs2_paddr == '0) || dispatch_rs2_ready;
    for (int k = 0; k < int'(NUM_CDB); k++) begin
      if (bcast_hit(cdb[k], dispatch_entry.rs1_paddr)) d_r1 = 1'b1;
      if (bcast_hit(cdb[k], dispatch_entry.rs2_paddr)) d_r2 = 1'b1;
    end
    ins_idx = count - CNT_W'(sel_found);
    count_n = count + CNT_W'(disp_acc) - CNT_W'(sel_found);
  end

  // Compaction with wakeup (match at source slot, write destination slot), then insert
  always_comb begin
    n_valid = '0;
    n_r1    = '0;
    n_r2    = '0;
    shift   = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      n_entry[i] = slot_entry[i];
      shift[i]   = sel_found && (IDX_W'(i) >= sel_idx);
      if (shift[i]) begin
        n_valid[i] = ext_valid[i+1];
        n_r1[i]    = ext_valid[i+1] & (ext_r1[i+1] | ext_w1[i+1]);
        n_r2[i]    = ext_valid[i+1] & (ext_r2[i+1] | ext_w2[i+1]);
        n_entry[i] = ext_entry[i+1];
      end else begin
        n_valid[i] = ext_valid[i];
        n_r1[i]    = ext_valid[i] & (ext_r1[i] | ext_w1[i]);
        n_r2[i]    = ext_valid[i] & (ext_r2[i] | ext_w2[i]);
        n_entry[i] = ext_entry[i];
      end
      if (disp_acc && (CNT_W'(i) == ins_idx)) begin
        n_valid[i] = 1'b1;
        n_r1[i]    = d_r1;
        n_r2[i]    = d_r2;
        n_entry[i] = dispatch_entry;
      end
    end
  end

  // Control state: reset and flush both empty the station
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      slot_valid <= '0;
      r1_rdy     <= '0;
      r2_rdy     <= '0;
      count      <= '0;
      full       <= 1'b0;
    end else begin
      slot_valid <= n_valid;
      r1_rdy     <= n_r1;
      r2_rdy     <= n_r2;
      count      <= count_n;
      full       <= (count_n == CNT_W'(DEPTH));
    end
  end

  // Payload storage is qualified by slot_valid and needs no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      slot_entry[i] <= n_entry[i];
    end
  end

  assign rs_count = count;
  assign rs_full  = full;

endmodule
